datapath_ctrl: RTL and testbench

Multi-cycle control sequencer for the register-file / MUX_B / function-unit datapath. It accepts one instruction word at a time over a valid/ready handshake and decodes it into the datapath control word: register addresses, MB, the CS constant, FS, MD and RW. It sequences each instruction through DECODE, EXECUTE and WRITE states, supports a conditional skip, and stalls load instructions on a data-ready input.

---
 rtl/datapath_ctrl.sv | 165 ++++++++++++++++
 tb/tb_datapath_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// Multi-cycle control sequencer for the register-file / MUX_B / function-unit datapath.
// Decodes one instruction per handshake into a registered control word, with skip-if-zero and load stall.
module datapath_ctrl #(
  parameter int REG_AW = 3,
  parameter int FS_W = 4,
  parameter int IMM_W = 8,
  localparam int INSTR_W = 1 + FS_W + 3 * REG_AW + 2 + IMM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               Z,
  input  logic               data_ready,
  output logic [REG_AW-1:0]  registerA,
  output logic [REG_AW-1:0]  registerB,
  output logic [REG_AW-1:0]  DA,
  output logic [IMM_W-1:0]   CS,
  output logic               MB,
  output logic [FS_W-1:0]    FS,
  output logic               MD,
  output logic               RW,
  output logic               done,
  output logic               skipped
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    WRITE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] da;
    logic [IMM_W-1:0]  cs;
    logic              mb;
    logic [FS_W-1:0]   fs;
    logic              md;
  } ctrl_t;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_SKIP = 2'b11;
  localparam ctrl_t CTRL_ZERO = {$bits(ctrl_t){1'b0}};

  // Field layout MSB..LSB: I, FS, DA, AA, BA, CLS, IMM.
  function automatic ctrl_t decode_instr(input logic [INSTR_W-1:0] word);
    ctrl_t c;
    c.mb = word[INSTR_W-1];
    c.fs = word[IMM_W + 2 + 3 * REG_AW +: FS_W];
    c.da = word[IMM_W + 2 + 2 * REG_AW +: REG_AW];
    c.ra = word[IMM_W + 2 + REG_AW +: REG_AW];
    c.rb = word[IMM_W + 2 +: REG_AW];
    c.md = (word[IMM_W +: 2] == CLS_LOAD);
    c.cs = word[INSTR_W-1] ? word[IMM_W-1:0] : {IMM_W{1'b0}};
    return c;
  endfunction

  state_t     state_r, state_nxt_s;
  ctrl_t      ctrl_r, ctrl_nxt_s;
  logic [1:0] cls_r, cls_nxt_s;
  logic       skip_r, skip_nxt_s;
  logic       rw_r, rw_nxt_s;
  logic       done_r, done_nxt_s;
  logic       skipped_r, skipped_nxt_s;
  logic       ready_r, ready_nxt_s;
  logic       accept_s;

  assign accept_s = instr_valid && ready_r;

  // Next-state and next-output decode; outputs are registered one step ahead of the state they belong to.
  always_comb begin
    state_nxt_s   = state_r;
    ctrl_nxt_s    = ctrl_r;
    cls_nxt_s     = cls_r;
    skip_nxt_s    = skip_r;
    rw_nxt_s      = 1'b0;
    done_nxt_s    = 1'b0;
    skipped_nxt_s = 1'b0;
    ready_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        ctrl_nxt_s = CTRL_ZERO;
        if (accept_s && skip_r) begin
          skip_nxt_s    = 1'b0;
          skipped_nxt_s = 1'b1;
          ready_nxt_s   = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = DECODE;
          ctrl_nxt_s  = decode_instr(instr);
          cls_nxt_s   = instr[IMM_W +: 2];
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      DECODE: begin
        state_nxt_s = EXECUTE;
      end
      EXECUTE: begin
        // Loads wait here for memory data; every other class leaves after one cycle.
        if ((cls_r != CLS_LOAD) || data_ready) begin
          state_nxt_s = WRITE;
          rw_nxt_s    = (cls_r == CLS_ALU) || (cls_r == CLS_LOAD);
          done_nxt_s  = 1'b1;
          if ((cls_r == CLS_SKIP) && Z) begin
            skip_nxt_s = 1'b1;
          end else begin
            skip_nxt_s = skip_r;
          end
        end else begin
          state_nxt_s = EXECUTE;
        end
      end
      WRITE: begin
        state_nxt_s = IDLE;
        ctrl_nxt_s  = CTRL_ZERO;
        ready_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
        ctrl_nxt_s  = CTRL_ZERO;
      end
    endcase
  end

  // State and registered control outputs; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      ctrl_r    <= CTRL_ZERO;
      cls_r     <= 2'b00;
      skip_r    <= 1'b0;
      rw_r      <= 1'b0;
      done_r    <= 1'b0;
      skipped_r <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ctrl_r    <= ctrl_nxt_s;
      cls_r     <= cls_nxt_s;
      skip_r    <= skip_nxt_s;
      rw_r      <= rw_nxt_s;
      done_r    <= done_nxt_s;
      skipped_r <= skipped_nxt_s;
      ready_r   <= ready_nxt_s;
    end
  end

  assign registerA   = ctrl_r.ra;
  assign registerB   = ctrl_r.rb;
  assign DA          = ctrl_r.da;
  assign CS          = ctrl_r.cs;
  assign MB          = ctrl_r.mb;
  assign FS          = ctrl_r.fs;
  assign MD          = ctrl_r.md;
  assign RW          = rw_r;
  assign done        = done_r;
  assign skipped     = skipped_r;
  assign instr_ready = ready_r;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: checks every output at each cycle of hand-traced sequences.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] instr = 24'h000000;
  logic        instr_valid = 1'b0;
  logic        Z = 1'b0;
  logic        data_ready = 1'b0;
  logic        instr_ready;
  logic [2:0]  registerA, registerB, DA;
  logic [7:0]  CS;
  logic        MB, MD, RW, done, skipped;
  logic [3:0]  FS;

  int n_cmp = 0;
  int n_err = 0;

  datapath_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Z(Z), .data_ready(data_ready),
    .registerA(registerA), .registerB(registerB), .DA(DA), .CS(CS), .MB(MB),
    .FS(FS), .MD(MD), .RW(RW), .done(done), .skipped(skipped)
  );

  always #5 clk = ~clk;

  logic [26:0] obs;
  assign obs = {registerA, registerB, DA, CS, MB, FS, MD, RW, done, skipped, instr_ready};

  function automatic logic [23:0] mk(input logic i, input logic [3:0] fs,
                                     input logic [2:0] da, input logic [2:0] aa,
                                     input logic [2:0] ba, input logic [1:0] cls,
                                     input logic [7:0] imm);
    return {i, fs, da, aa, ba, cls, imm};
  endfunction

  function automatic logic [26:0] ev(input logic [2:0] ra, input logic [2:0] rb,
                                     input logic [2:0] da, input logic [7:0] cs,
                                     input logic mb, input logic [3:0] fs, input logic md,
                                     input logic rw, input logic dn, input logic sk,
                                     input logic rdy);
    return {ra, rb, da, cs, mb, fs, md, rw, dn, sk, rdy};
  endfunction

  task automatic chk(input string tag, input logic [26:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [26:0] idle_rdy, all_zero;

  initial begin
    idle_rdy = ev(3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    all_zero = ev(3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held for three edges, then released.
    repeat (3) tick();
    chk("reset_hold", all_zero);
    reset = 1'b0;
    tick();
    chk("reset_release", idle_rdy);

    // ALU register op.
    instr = mk(1'b0, 4'b0010, 3'd5, 3'd1, 3'd3, 2'b00, 8'h77);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = mk(1'b1, 4'hF, 3'd7, 3'd7, 3'd7, 2'b11, 8'hFF);
    chk("alu_c1", ev(3'd1, 3'd3, 3'd5, 8'h00, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("alu_c2", ev(3'd1, 3'd3, 3'd5, 8'h00, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("alu_c3", ev(3'd1, 3'd3, 3'd5, 8'h00, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("alu_c4", idle_rdy);

    // Immediate op.
    instr = mk(1'b1, 4'b0101, 3'd2, 3'd4, 3'd7, 2'b00, 8'hA5);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("imm_c1", ev(3'd4, 3'd7, 3'd2, 8'hA5, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("imm_c2", ev(3'd4, 3'd7, 3'd2, 8'hA5, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("imm_c3", ev(3'd4, 3'd7, 3'd2, 8'hA5, 1'b1, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("imm_c4", idle_rdy);

    // Load stalled by data_ready for four EXECUTE cycles.
    instr = mk(1'b0, 4'h0, 3'd6, 3'd2, 3'd0, 2'b01, 8'h00);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ld_dec", ev(3'd2, 3'd0, 3'd6, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ld_stall", ev(3'd2, 3'd0, 3'd6, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    tick();
    data_ready = 1'b1;
    chk("ld_rise", ev(3'd2, 3'd0, 3'd6, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    data_ready = 1'b0;
    chk("ld_write", ev(3'd2, 3'd0, 3'd6, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("ld_idle", idle_rdy);

    // Skip-if-zero taken (Z=1).
    instr = mk(1'b0, 4'h0, 3'd1, 3'd1, 3'd1, 2'b11, 8'h00);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("skz_dec", ev(3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    Z = 1'b1;
    tick();
    Z = 1'b0;
    chk("skz_write", ev(3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("skz_idle", idle_rdy);
    tick();
    instr = mk(1'b0, 4'h3, 3'd4, 3'd5, 3'd6, 2'b00, 8'h00);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("skz_skipped", ev(3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    tick();
    chk("skz_after", idle_rdy);
    instr = mk(1'b1, 4'h1, 3'd7, 3'd0, 3'd2, 2'b00, 8'h3C);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("skz_b_c1", ev(3'd0, 3'd2, 3'd7, 8'h3C, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    tick();
    chk("skz_b_c3", ev(3'd0, 3'd2, 3'd7, 8'h3C, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("skz_b_c4", idle_rdy);

    // Skip-if-zero not taken (Z=0).
    instr = mk(1'b0, 4'h0, 3'd1, 3'd1, 3'd1, 2'b11, 8'h00);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk("snz_write", ev(3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    instr = mk(1'b0, 4'h3, 3'd4, 3'd5, 3'd6, 2'b00, 8'h00);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("snz_a_c1", ev(3'd5, 3'd6, 3'd4, 8'h00, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    tick();
    chk("snz_a_c3", ev(3'd5, 3'd6, 3'd4, 8'h00, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("snz_a_c4", idle_rdy);

    // instr_valid held high with instr changing every cycle.
    instr = mk(1'b0, 4'h6, 3'd2, 3'd3, 3'd4, 2'b10, 8'h11);
    instr_valid = 1'b1;
    tick();
    instr = mk(1'b1, 4'hE, 3'd0, 3'd0, 3'd0, 2'b00, 8'hEE);
    chk("cv_c1", ev(3'd3, 3'd4, 3'd2, 8'h00, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    instr = mk(1'b1, 4'hD, 3'd1, 3'd1, 3'd1, 2'b01, 8'hDD);
    tick();
    instr = mk(1'b1, 4'hC, 3'd3, 3'd3, 3'd3, 2'b00, 8'hCC);
    chk("cv_c3_cmp", ev(3'd3, 3'd4, 3'd2, 8'h00, 1'b0, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    instr = mk(1'b1, 4'h9, 3'd6, 3'd5, 3'd1, 2'b00, 8'h5A);
    chk("cv_c4", idle_rdy);
    tick();
    instr = mk(1'b0, 4'hB, 3'd7, 3'd7, 3'd7, 2'b01, 8'hBB);
    chk("cv_c5", ev(3'd5, 3'd1, 3'd6, 8'h5A, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    tick();
    instr_valid = 1'b0;
    chk("cv_c7", ev(3'd5, 3'd1, 3'd6, 8'h5A, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("cv_c8", idle_rdy);

    // Asynchronous reset while in EXECUTE.
    instr = mk(1'b0, 4'h1, 3'd3, 3'd2, 3'd1, 2'b00, 8'h00);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("ar_exec", ev(3'd2, 3'd1, 3'd3, 8'h00, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    chk("ar_async", all_zero);
    tick();
    chk("ar_held", all_zero);
    reset = 1'b0;
    tick();
    chk("ar_release", idle_rdy);
    tick();
    chk("ar_no_rw", idle_rdy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
